stable_matching_comb: RTL and testbench

- Clocked engine that computes a stable matching between list A (S proposers, each with Ks ranked choices over list B) and list B (R acceptors, each with Kr ranked choices over list A).
- Runs the Gale-Shapley deferred-acceptance algorithm, one proposal per clock, from a packed preference bus.
- Outputs, per list-B member, the index of its matched list-A member, plus a completion flag.
- Used as the matching core in the stable-matching datapath.

---
 rtl/stable_matching_comb.sv | 170 +++++++++++++++++
 tb/tb_stable_matching_comb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stable_matching_comb.sv
// stable_matching_comb
//   Gale-Shapley deferred-acceptance engine. List-A members (proposers) work
//   down their ranked lists of list-B members (acceptors), one proposal per
//   clock. The engine stops when no free proposer has choices left, or when
//   the proposal cap N is reached. The result is then held until reset.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   g          packed preferences {sPref, rPref}; hold stable while running
//                rPref[r][k] = g[(r*Kr+k)*logS +: logS]
//                sPref[s][k] = g[R*Kr*logS + (s*Ks+k)*logR +: logR]
//   o          {finish, matchList}; matchList slice r = partner of acceptor r
//   r_matched  acceptor r currently holds a partner

// Rank lookup for one acceptor. It finds the first (best) position of two
// keys in that acceptor's preference list. Entries >= S never equal a key,
// because keys are always valid proposer indices.
module stable_matching_rank #(
    parameter int Kr   = 2,
    parameter int logS = 2,
    localparam int RKW = (Kr > 1) ? $clog2(Kr) : 1
) (
    input  logic [Kr-1:0][logS-1:0] pref,
    input  logic [logS-1:0]         key_a,
    input  logic [logS-1:0]         key_b,
    output logic                    hit_a,
    output logic [RKW-1:0]          rank_a,
    output logic [RKW-1:0]          rank_b
);
    always_comb begin
        hit_a  = 1'b0;
        rank_a = '0;
        rank_b = '0;
        // Scan from the back so the lowest matching position wins.
        for (int k = Kr - 1; k >= 0; k--) begin
            if (pref[k] == key_a) begin
                hit_a  = 1'b1;
                rank_a = RKW'(k);
            end
            if (pref[k] == key_b) rank_b = RKW'(k);
        end
    end
endmodule

module stable_matching_comb #(
    parameter int Kr = 2,
    parameter int Ks = 2,
    parameter int S  = 3,
    parameter int R  = 3,
    parameter int N  = S*S - S + 2,
    localparam int logS = $clog2(S),
    localparam int logR = $clog2(R),
    localparam int GW   = R*Kr*logS + S*Ks*logR,
    localparam int OW   = R*logS + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [GW-1:0] g,
    output logic [OW-1:0] o,
    output logic [R-1:0]  r_matched
);
    localparam int PW  = $clog2(Ks + 1);
    localparam int CW  = $clog2(N + 1);
    localparam int RKW = (Kr > 1) ? $clog2(Kr) : 1;

    logic [R-1:0][Kr-1:0][logS-1:0] rpref;
    logic [S-1:0][Ks-1:0][logR-1:0] spref;
    assign rpref = g[R*Kr*logS-1:0];
    assign spref = g[GW-1 -: S*Ks*logR];

    logic [S-1:0][PW-1:0]   ptr;
    logic [S-1:0]           s_matched;
    logic [R-1:0][logS-1:0] partner;
    logic [CW-1:0]          cnt;
    logic                   finish;

    assign o = {finish, partner};

    // Lowest-index free proposer that still has choices left.
    logic [logS-1:0] sel;
    logic            any_elig;
    logic [logR-1:0] cur_r;

    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        for (int i = S - 1; i >= 0; i--) begin
            if (!s_matched[i] && (ptr[i] < PW'(Ks))) begin
                sel      = logS'(i);
                any_elig = 1'b1;
            end
        end
        cur_r = '0;
        for (int i = 0; i < S; i++)
            for (int k = 0; k < Ks; k++)
                if (sel == logS'(i) && ptr[i] == PW'(k)) cur_r = spref[i][k];
    end

    logic [R-1:0]           hit_s;
    logic [R-1:0][RKW-1:0]  rank_s;
    logic [R-1:0][RKW-1:0]  rank_p;

    for (genvar r = 0; r < R; r++) begin : g_rank
        stable_matching_rank #(.Kr(Kr), .logS(logS)) u_rank (
            .pref   (rpref[r]),
            .key_a  (sel),
            .key_b  (partner[r]),
            .hit_a  (hit_s[r]),
            .rank_a (rank_s[r]),
            .rank_b (rank_p[r])
        );
    end

    // An out-of-range target (cur_r >= R) never equals any r, so it falls
    // through as a rejection. The current partner always appears in the
    // list, so rank_p is always meaningful when r_matched is set.
    logic            accept;
    logic            disp_vld;
    logic [logS-1:0] disp;

    always_comb begin
        accept   = 1'b0;
        disp_vld = 1'b0;
        disp     = '0;
        for (int r = 0; r < R; r++) begin
            if (cur_r == logR'(r) && hit_s[r] &&
                (!r_matched[r] || rank_s[r] < rank_p[r])) begin
                accept   = 1'b1;
                disp_vld = r_matched[r];
                disp     = partner[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            s_matched <= '0;
            partner   <= '0;
            r_matched <= '0;
            cnt       <= '0;
            finish    <= 1'b0;
        end else if (!finish) begin
            if (!any_elig || cnt == CW'(N)) begin
                finish <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
                for (int i = 0; i < S; i++)
                    if (sel == logS'(i)) ptr[i] <= ptr[i] + PW'(1);
                if (accept) begin
                    for (int r = 0; r < R; r++) begin
                        if (cur_r == logR'(r)) begin
                            partner[r]   <= sel;
                            r_matched[r] <= 1'b1;
                        end
                    end
                    // The displaced proposer keeps its pointer and resumes
                    // from its next choice.
                    for (int i = 0; i < S; i++) begin
                        if (sel == logS'(i))
                            s_matched[i] <= 1'b1;
                        else if (disp_vld && disp == logS'(i))
                            s_matched[i] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_stable_matching_comb.sv
module tb_stable_matching_comb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] g   = '0;
    logic [6:0]  o, o2;
    logic [2:0]  rm, rm2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stable_matching_comb dut (
        .clk(clk), .rst(rst), .g(g), .o(o), .r_matched(rm)
    );

    stable_matching_comb #(.N(2)) dut_cap (
        .clk(clk), .rst(rst), .g(g), .o(o2), .r_matched(rm2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Six 2-bit entries; element 0 sits in the low bits.
    function automatic logic [11:0] mk_pref(input int a0, a1, b0, b1, c0, c1);
        logic [11:0] v;
        v = {2'(c1), 2'(c0), 2'(b1), 2'(b0), 2'(a1), 2'(a0)};
        return v;
    endfunction

    function automatic logic [6:0] mk_o(input int m0, m1, m2, input bit fin);
        logic [6:0] v;
        v = {fin, 2'(m2), 2'(m1), 2'(m0)};
        return v;
    endfunction

    // Reference: deferred acceptance described per acceptor (who it holds),
    // with freedom of a proposer derived from whether anyone holds it.
    function automatic int rrank(input logic [23:0] gg, input int r, input int x);
        for (int k = 0; k < 2; k++)
            if (int'(gg[(r*2+k)*2 +: 2]) == x) return k;
        return -1;
    endfunction

    function automatic void model(input logic [23:0] gg, input int n,
                                  output logic [6:0] eo, output logic [2:0] erm,
                                  output int edges);
        int holder[3];
        int nxt[3];
        int props;
        int s, r, rk;
        bit held;
        for (int i = 0; i < 3; i++) begin holder[i] = -1; nxt[i] = 0; end
        props = 0;
        edges = 0;
        while (1) begin
            edges++;
            s = -1;
            for (int i = 2; i >= 0; i--) begin
                held = 0;
                for (int j = 0; j < 3; j++) if (holder[j] == i) held = 1;
                if (!held && nxt[i] < 2) s = i;
            end
            if (s < 0 || props == n) break;
            props++;
            r = int'(gg[12 + (s*2+nxt[s])*2 +: 2]);
            nxt[s]++;
            if (r < 3) begin
                rk = rrank(gg, r, s);
                if (rk >= 0 && (holder[r] < 0 || rk < rrank(gg, r, holder[r])))
                    holder[r] = s;
            end
        end
        eo  = {1'b1, 6'b0};
        erm = '0;
        for (int j = 0; j < 3; j++)
            if (holder[j] >= 0) begin
                eo[j*2 +: 2] = 2'(holder[j]);
                erm[j] = 1'b1;
            end
    endfunction

    // Counts blocking pairs in a DUT result.
    function automatic int blocking(input logic [23:0] gg, input logic [6:0] oo, input logic [2:0] mm);
        int cnt, r, srank, cur, rs, rp;
        cnt = 0;
        for (int s = 0; s < 3; s++) begin
            cur = 99;
            for (int k = 1; k >= 0; k--) begin
                r = int'(gg[12 + (s*2+k)*2 +: 2]);
                if (r < 3 && mm[r] && int'(oo[r*2 +: 2]) == s) cur = k;
            end
            for (int k = 0; k < 2; k++) begin
                r = int'(gg[12 + (s*2+k)*2 +: 2]);
                srank = k;
                for (int j = k - 1; j >= 0; j--)
                    if (int'(gg[12 + (s*2+j)*2 +: 2]) == r) srank = j;
                if (r < 3 && srank < cur) begin
                    rs = rrank(gg, r, s);
                    rp = mm[r] ? rrank(gg, r, int'(oo[r*2 +: 2])) : 99;
                    if (rs >= 0 && rs < rp) cnt++;
                end
            end
        end
        return cnt;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Edge count (from reset release) at which each DUT first shows finish.
    int e1, e2;
    task automatic run_to_finish();
        e1 = 99; e2 = 99;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (o2[6] && e2 == 99) e2 = e;
            if (o[6]) begin e1 = e; break; end
        end
        if (e2 == 99 && o2[6]) e2 = e1;
    endtask

    typedef struct {
        string       name;
        logic [23:0] g;
        int          edges;
        logic [6:0]  o;
        logic [2:0]  rm;
    } vec_t;

    vec_t vecs[4];
    logic [11:0] sp1, rp1;

    initial begin
        logic [6:0] eo;
        logic [2:0] erm;
        int ee, ec;
        logic [6:0] eo2;
        logic [2:0] erm2;

        sp1 = mk_pref(0, 1, 0, 2, 1, 0);
        rp1 = mk_pref(1, 0, 0, 2, 1, 2);
        vecs[0] = '{"basic",    {sp1, rp1}, 6, mk_o(1, 0, 0, 1), 3'b011};
        vecs[1] = '{"disjoint", {mk_pref(0,0,1,1,2,2), mk_pref(0,0,1,1,2,2)}, 4, mk_o(0,1,2,1), 3'b111};
        vecs[2] = '{"noaccept", {sp1, mk_pref(3,3,3,3,3,3)}, 7, mk_o(0,0,0,1), 3'b000};
        vecs[3] = '{"allr0",    {mk_pref(0,1,0,2,0,1), mk_pref(2,1,0,1,1,0)}, 6, mk_o(2,0,1,1), 3'b111};

        // Reset state
        g = vecs[0].g;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o", 32'(o), 0);
        chk("reset_rm", 32'(rm), 0);

        for (int i = 0; i < 4; i++) begin
            g = vecs[i].g;
            do_reset();
            run_to_finish();
            chk({vecs[i].name, "_edges"}, e1, vecs[i].edges);
            chk({vecs[i].name, "_o"}, 32'(o), 32'(vecs[i].o));
            chk({vecs[i].name, "_rm"}, 32'(rm), 32'(vecs[i].rm));
            repeat (3) @(posedge clk);
            #1;
            chk({vecs[i].name, "_frozen"}, 32'({o, rm}), 32'({vecs[i].o, vecs[i].rm}));
            if (i == 0) begin
                chk("cap_edges", e2, 3);
                chk("cap_o", 32'(o2), 32'(mk_o(1, 0, 0, 1)));
                chk("cap_rm", 32'(rm2), 3'b001);
            end
        end

        // Asynchronous reset mid-run, then an identical rerun.
        g = vecs[0].g;
        do_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_o", 32'(o), 0);
        chk("midrst_rm", 32'(rm), 0);
        @(negedge clk);
        rst = 1'b0;
        run_to_finish();
        chk("rerun_edges", e1, 6);
        chk("rerun_o", 32'(o), 32'(mk_o(1, 0, 0, 1)));
        chk("rerun_rm", 32'(rm), 3'b011);

        // Randomized preferences against the reference model.
        for (int t = 0; t < 40; t++) begin
            g = 24'($urandom);
            model(g, 8, eo, erm, ee);
            model(g, 2, eo2, erm2, ec);
            do_reset();
            run_to_finish();
            chk("rand_edges", e1, ee);
            chk("rand_o", 32'(o), 32'(eo));
            chk("rand_rm", 32'(rm), 32'(erm));
            chk("rand_stable", blocking(g, o, rm), 0);
            chk("rand_cap", 32'({o2, rm2}), 32'({eo2, erm2}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
